// File: rtl/stack_cmd_ctrl.sv
// ============================================================================
// Module   : stack_cmd_ctrl
// Desc     : Valid/ready command front-end for a WIDTH x DEPTH stack. Turns
//            PUSH/POP/PEEK commands into one-cycle stack strobes and returns
//            data plus an error flag. Optional macro STACK_CMD_CTRL_COUNT_EN
//            adds an occupancy counter that drives the full/empty decisions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_cmd_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic                     stk_push,
    output logic                     stk_pop,
    output logic [WIDTH-1:0]         stk_value_in,
    input  logic [WIDTH-1:0]         stk_value_out,
    input  logic                     stk_full,
    input  logic                     stk_empty
`ifdef STACK_CMD_CTRL_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]   occupancy
`endif
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   data_q;

    logic               full_w;
    logic               empty_w;
    logic               flag_err_w;
    logic               in_issue_w;
    logic               do_push_w;
    logic               do_pop_w;
    logic               do_peek_w;

`ifdef STACK_CMD_CTRL_COUNT_EN
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] occ_q;

    // Counter is authoritative; disagreement with the stack flags is an error.
    assign full_w     = (occ_q == DEPTH_C);
    assign empty_w    = (occ_q == '0);
    assign flag_err_w = (full_w != stk_full) || (empty_w != stk_empty);
    assign occupancy  = occ_q;
`else
    assign full_w     = stk_full;
    assign empty_w    = stk_empty;
    assign flag_err_w = 1'b0;
`endif

    // Strobes depend on flags sampled during ISSUE, so they cannot be registered.
    assign in_issue_w = (state_q == S_ISSUE) && !flag_err_w;
    assign do_push_w  = in_issue_w && (op_q == OP_PUSH) && !full_w;
    assign do_pop_w   = in_issue_w && (op_q == OP_POP)  && !empty_w;
    assign do_peek_w  = in_issue_w && (op_q == OP_PEEK) && !empty_w;

    assign stk_push     = do_push_w;
    assign stk_pop      = do_pop_w;
    assign stk_value_in = do_push_w ? data_q : '0;

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            op_q        <= 2'b00;
            data_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    if (do_push_w) begin
                        rsp_data_q <= data_q;
                        rsp_err_q  <= 1'b0;
                    end else if (do_pop_w || do_peek_w) begin
                        rsp_data_q <= stk_value_out;
                        rsp_err_q  <= 1'b0;
                    end else begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef STACK_CMD_CTRL_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else if (do_push_w) begin
            occ_q <= occ_q + 1'b1;
        end else if (do_pop_w) begin
            occ_q <= occ_q - 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_cmd_ctrl.sv
// ============================================================================
// Module   : tb_stack_cmd_ctrl
// Desc     : Scoreboard bench for stack_cmd_ctrl with a behavioural 8-deep
//            stack attached and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_cmd_ctrl;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [WIDTH-1:0]  cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_err;
    logic              stk_push;
    logic              stk_pop;
    logic [WIDTH-1:0]  stk_value_in;
    logic [WIDTH-1:0]  stk_value_out;
    logic              stk_full;
    logic              stk_empty;
`ifdef STACK_CMD_CTRL_COUNT_EN
    logic [$clog2(DEPTH):0] occupancy;
`endif

    int total = 0;
    int bad   = 0;

    stack_cmd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_value_in  (stk_value_in),
        .stk_value_out (stk_value_out),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty)
`ifdef STACK_CMD_CTRL_COUNT_EN
        ,
        .occupancy     (occupancy)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural stack the controller drives.
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp = 0;

    always @(posedge clk) begin
        if (stk_push && sp < DEPTH) begin
            mem[sp] <= stk_value_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    always_comb begin
        stk_value_out = '0;
        if (sp > 0) stk_value_out = mem[sp-1];
        stk_full  = (sp == DEPTH);
        stk_empty = (sp == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected response and strobe kind (0 none, 1 push, 2 pop).
    typedef struct {
        logic [WIDTH-1:0] d;
        logic             e;
        int               strobe;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ref_stk[$];

    function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] d);
        exp_t r;
        r.d = '0; r.e = 1'b1; r.strobe = 0;
        case (op)
            2'b00: if (ref_stk.size() < DEPTH) begin
                ref_stk.push_back(d);
                r.d = d; r.e = 1'b0; r.strobe = 1;
            end
            2'b01: if (ref_stk.size() > 0) begin
                r.d = ref_stk.pop_back(); r.e = 1'b0; r.strobe = 2;
            end
            2'b10: if (ref_stk.size() > 0) begin
                r.d = ref_stk[$]; r.e = 1'b0;
            end
            default: ;
        endcase
        return r;
    endfunction

    // Response ready driver: random or forced level.
    logic rr_mode = 1'b0;
    logic rr_val  = 1'b1;

    initial forever begin
        @(posedge clk);
        #2;
        if (rr_mode) rsp_ready = ($urandom_range(0, 3) != 0);
        else         rsp_ready = rr_val;
    end

    // Monitor: strobe sanity, response stability, scoreboard compare.
    int               seen_push = 0;
    int               seen_pop  = 0;
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_err  = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            seen_push = 0;
            seen_pop  = 0;
            prev_hold = 1'b0;
        end else begin
            if (stk_push && stk_pop) chk("strobe_excl", 32'd1, 32'd0);
            if (!stk_push && stk_value_in !== '0) chk("value_in_idle", 32'(stk_value_in), 32'd0);
            if (cmd_ready && rsp_valid) chk("ready_vs_valid", 32'd1, 32'd0);
            if (stk_push) seen_push++;
            if (stk_pop)  seen_pop++;
            if (prev_hold) begin
                chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
                chk("rsp_hold_err", 32'(rsp_err), 32'(prev_err));
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_err  = rsp_err;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.d));
                    chk("rsp_err", 32'(rsp_err), 32'(e.e));
                    chk("push_pulses", 32'(seen_push), (e.strobe == 1) ? 32'd1 : 32'd0);
                    chk("pop_pulses", 32'(seen_pop), (e.strobe == 2) ? 32'd1 : 32'd0);
                end
                seen_push = 0;
                seen_pop  = 0;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(op, d));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        int               n;

        // Reset values while held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
        chk("rst_value_in", 32'(stk_value_in), 32'd0);

        // Release, ready rises one edge later; then interrupt a PUSH in ISSUE.
        @(negedge clk);
        reset = 1'b1;
        #1 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 chk("ready_after_release", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'hA5A5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("issue_push", 32'(stk_push), 32'd1);
        chk("issue_value_in", 32'(stk_value_in), 32'h0000A5A5);
        #2 reset = 1'b0;
        #1;
        chk("async_push_drop", 32'(stk_push), 32'd0);
        chk("async_value_in", 32'(stk_value_in), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rerelease", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        end
        chk("stack_untouched", 32'(sp), 32'd0);

        // Empty POP and reserved op.
        send(2'b01, 16'h0000);
        send(2'b11, 16'h5555);
        // PUSH then POP.
        send(2'b00, 16'h1234);
        send(2'b01, 16'h0000);
        drain();
        chk("empty_after_pop", 32'(sp), 32'd0);
        // PEEK leaves stack alone.
        send(2'b00, 16'hBEEF);
        send(2'b10, 16'h0000);
        send(2'b10, 16'h0000);
        drain();
        chk("peek_keeps_depth", 32'(sp), 32'd1);
        send(2'b01, 16'h0000);
        // Fill, overflow, pop top.
        for (int i = 1; i <= 8; i++) send(2'b00, 16'(i));
        send(2'b00, 16'hFFFF);
        send(2'b01, 16'h0000);
        drain();
        chk("depth_after_overflow", 32'(sp), 32'd7);

        // Backpressure on a POP response.
        rr_val = 1'b0;
        send(2'b01, 16'h0000);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", 32'(rsp_data), 32'(held));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rr_val = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        drain();

        // Randomized traffic with random response backpressure.
        rr_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            send(op, 16'($urandom));
        end
        drain();
        chk("final_depth", 32'(sp), 32'(ref_stk.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
